// File: rtl/adc_sample_qualifier.sv
// adc_sample_qualifier: per-channel ADC sample gate between the ADC CDC FIFO and pid_pipeline.
//  Drops samples from shut-down channels, zero codes and step outliers, latches a
//  per-channel fault after N_FAULT consecutive rejects, forwards qualified samples.
//  Ports:
//   clk_in, rst_in           pid clock, asynchronous active-high reset
//   shutdown_in[N_CHAN]      asynchronous per-channel hardware shutdown level
//   dv_in/chan_in/data_in    sample stream from the ADC FIFO
//   wr_en/wr_addr/wr_data    config writes (step threshold, fault clear mask)
//   dv_out/chan_out/data_out qualified sample, 2-cycle latency, dv_out is a 1-cycle pulse
//   fault_out[N_CHAN]        latched per-channel fault
module adc_sample_qualifier #(
  parameter int N_CHAN = 8,
  parameter int W_CHAN = 3,
  parameter int W_DATA = 18,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_DATA = 16,
  parameter int DEB_LEN = 64,
  parameter int N_FAULT = 4,
  parameter logic [W_WR_ADDR-1:0] THR_ADDR = 16'h40,
  parameter logic [W_WR_ADDR-1:0] CLR_ADDR = 16'h41
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N_CHAN-1:0]    shutdown_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out,
  output logic [N_CHAN-1:0]    fault_out
);
  localparam int W_DEB = $clog2(DEB_LEN + 1);
  localparam logic [W_DEB-1:0] L_DEB = W_DEB'(DEB_LEN);
  localparam logic [3:0] L_NF = 4'(N_FAULT);
  logic [N_CHAN-1:0] r_sd_meta, r_sd_sync, r_killed;
  logic [W_DEB-1:0] r_deb [N_CHAN];
  logic r_s1_dv;
  logic [W_CHAN-1:0] r_s1_chan;
  logic [W_DATA-1:0] r_s1_data;
  logic [W_WR_DATA-1:0] r_thr;
  logic [3:0] r_cnt [N_CHAN];
  logic [N_CHAN-1:0] r_ref_valid, r_fault;
  logic [W_DATA-1:0] r_ref [N_CHAN];
  logic r_dv;
  logic [W_CHAN-1:0] r_chan;
  logic [W_DATA-1:0] r_data;
  logic [W_DATA-1:0] w_ref;
  logic [W_DATA:0] w_diff, w_mag;
  logic w_killed, w_faulted, w_step, w_live, w_reject, w_accept;
  logic [N_CHAN-1:0] w_clr;
  // Shutdown synchronizer and release debounce: any synchronized high re-arms the full
  // DEB_LEN count, so a channel only comes back after an unbroken low stretch.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_sd_meta <= '0;
      r_sd_sync <= '0;
      r_killed <= '1;
      for (int c = 0; c < N_CHAN; c++) r_deb[c] <= L_DEB;
    end else begin
      r_sd_meta <= shutdown_in;
      r_sd_sync <= r_sd_meta;
      for (int c = 0; c < N_CHAN; c++)
        if (r_sd_sync[c]) begin
          r_killed[c] <= 1'b1;
          r_deb[c] <= L_DEB;
        end else if (r_killed[c]) begin
          r_deb[c] <= r_deb[c] - W_DEB'(1);
          if (r_deb[c] == W_DEB'(1)) r_killed[c] <= 1'b0;
        end
    end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_s1_dv <= 1'b0;
      r_s1_chan <= '0;
      r_s1_data <= '0;
    end else begin
      r_s1_dv <= dv_in;
      if (dv_in) begin
        r_s1_chan <= chan_in;
        r_s1_data <= data_in;
      end
    end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) r_thr <= '0;
    else if (wr_en && wr_addr == THR_ADDR) r_thr <= wr_data;
  // Stage-2 decision. The step difference is sign-extended by one bit so that the
  // full-scale negative vs positive case cannot wrap; its magnitude is unsigned.
  assign w_ref = r_ref[r_s1_chan];
  assign w_killed = r_killed[r_s1_chan];
  assign w_faulted = r_fault[r_s1_chan];
  assign w_diff = {r_s1_data[W_DATA-1], r_s1_data} - {w_ref[W_DATA-1], w_ref};
  assign w_mag = w_diff[W_DATA] ? -w_diff : w_diff;
  assign w_step = |r_thr && r_ref_valid[r_s1_chan] &&
                  ({{W_WR_DATA{1'b0}}, w_mag} > {{(W_DATA+1){1'b0}}, r_thr});
  assign w_live = r_s1_dv && !w_killed && !w_faulted;
  assign w_reject = w_live && (r_s1_data == '0 || w_step);
  assign w_accept = w_live && !w_reject;
  assign w_clr = (wr_en && wr_addr == CLR_ADDR) ? wr_data[N_CHAN-1:0] : '0;
  // Per-channel state; a clear on a channel overrides whatever its stage-2 sample did.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_fault <= '0;
      r_ref_valid <= '0;
      for (int c = 0; c < N_CHAN; c++) begin
        r_cnt[c] <= '0;
        r_ref[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CHAN; c++)
        if (w_clr[c]) begin
          r_fault[c] <= 1'b0;
          r_cnt[c] <= '0;
          r_ref_valid[c] <= 1'b0;
        end else if (r_s1_dv && r_s1_chan == W_CHAN'(c)) begin
          if (w_killed) r_ref_valid[c] <= 1'b0;
          if (w_reject) begin
            r_cnt[c] <= (r_cnt[c] == L_NF) ? r_cnt[c] : r_cnt[c] + 4'd1;
            r_fault[c] <= r_fault[c] | (r_cnt[c] >= L_NF - 4'd1);
          end
          if (w_accept) begin
            r_cnt[c] <= '0;
            r_ref_valid[c] <= 1'b1;
            r_ref[c] <= r_s1_data;
          end
        end
    end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_dv <= 1'b0;
      r_chan <= '0;
      r_data <= '0;
    end else begin
      r_dv <= w_accept;
      if (w_accept) begin
        r_chan <= r_s1_chan;
        r_data <= r_s1_data;
      end
    end
  assign dv_out = r_dv;
  assign chan_out = r_chan;
  assign data_out = r_data;
  assign fault_out = r_fault;
endmodule

// File: tb/tb_adc_sample_qualifier.sv
// tb_adc_sample_qualifier: randomized and directed checks against a sequential reference model
module tb_adc_sample_qualifier;
  localparam int DEB = 64;
  localparam int NF = 4;
  localparam logic [15:0] THR = 16'h40;
  localparam logic [15:0] CLR = 16'h41;
  typedef struct {
    bit dv;
    int ch;
    int d;
    bit we;
    logic [15:0] a;
    logic [15:0] w;
  } op_t;
  logic clk_in = 1'b0;
  logic rst_in;
  logic [7:0] shutdown_in;
  logic dv_in;
  logic [2:0] chan_in;
  logic [17:0] data_in;
  logic wr_en;
  logic [15:0] wr_addr, wr_data;
  logic dv_out;
  logic [2:0] chan_out;
  logic [17:0] data_out;
  logic [7:0] fault_out;
  int n_tests = 0;
  int n_fail = 0;
  bit m_killed [8];
  bit m_fault [8];
  bit m_refv [8];
  int m_cnt [8];
  int m_ref [8];
  int m_thr;
  bit p_dv;
  int p_ch, p_d;
  bit e_dv;
  logic [2:0] e_ch;
  logic [17:0] e_data;
  logic [7:0] e_fault;
  adc_sample_qualifier dut (
    .clk_in(clk_in), .rst_in(rst_in), .shutdown_in(shutdown_in), .dv_in(dv_in),
    .chan_in(chan_in), .data_in(data_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out),
    .fault_out(fault_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic op_t smp(input int ch, input int d);
    op_t o;
    o = '{1'b1, ch, d, 1'b0, 16'h0, 16'h0};
    return o;
  endfunction
  function automatic op_t idl();
    op_t o;
    o = '{1'b0, 0, 0, 1'b0, 16'h0, 16'h0};
    return o;
  endfunction
  function automatic op_t wr(input logic [15:0] a, input logic [15:0] w);
    op_t o;
    o = '{1'b0, 0, 0, 1'b1, a, w};
    return o;
  endfunction
  function automatic void m_reset();
    for (int c = 0; c < 8; c++) begin
      m_killed[c] = 1;
      m_fault[c] = 0;
      m_refv[c] = 0;
      m_cnt[c] = 0;
      m_ref[c] = 0;
    end
    m_thr = 0;
    p_dv = 0;
  endfunction
  function automatic void m_release();
    for (int c = 0; c < 8; c++) m_killed[c] = 0;
  endfunction
  function automatic bit decide(input int ch, input int d);
    int diff;
    if (m_killed[ch]) begin
      m_refv[ch] = 0;
      return 0;
    end
    if (m_fault[ch]) return 0;
    diff = d - m_ref[ch];
    if (diff < 0) diff = -diff;
    if (d == 0 || (m_thr != 0 && m_refv[ch] && diff > m_thr)) begin
      if (m_cnt[ch] < NF) m_cnt[ch]++;
      if (m_cnt[ch] == NF) m_fault[ch] = 1;
      return 0;
    end
    m_ref[ch] = d;
    m_refv[ch] = 1;
    m_cnt[ch] = 0;
    return 1;
  endfunction
  // Drives one cycle. The sample driven in the previous call is decided at the coming
  // edge, together with this call's write; its expected result is left in e_*.
  task automatic issue(input op_t o);
    dv_in = o.dv;
    chan_in = 3'(o.ch);
    data_in = 18'(o.d);
    wr_en = o.we;
    wr_addr = o.a;
    wr_data = o.w;
    e_dv = p_dv ? decide(p_ch, p_d) : 1'b0;
    e_ch = 3'(p_ch);
    e_data = 18'(p_d);
    if (o.we && o.a == THR) m_thr = int'(o.w);
    if (o.we && o.a == CLR)
      for (int c = 0; c < 8; c++)
        if (o.w[c]) begin
          m_fault[c] = 0;
          m_cnt[c] = 0;
          m_refv[c] = 0;
        end
    for (int c = 0; c < 8; c++) e_fault[c] = m_fault[c];
    p_dv = o.dv;
    p_ch = o.ch;
    p_d = o.d;
    @(posedge clk_in);
    #1;
  endtask
  task automatic test_reset();
    op_t q[$];
    n_tests++;
    if ({dv_out, chan_out, data_out, fault_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got dv=%b ch=%0d data=%h fault=%h, want all 0", dv_out, chan_out, data_out, fault_out);
    end
    rst_in = 1'b0;
    q.push_back(smp(2, 5));
    repeat (3) q.push_back(idl());
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL reset_killed: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_release();
    for (int i = 0; i < DEB + 5; i++) begin
      if (i == DEB + 2) m_release();
      issue(i == DEB + 2 ? smp(2, 100) : idl());
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL release i=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_kill();
    op_t o;
    for (int i = 0; i < 11 + DEB + 8; i++) begin
      o = idl();
      if (i == 0) shutdown_in[5] = 1'b1;
      if (i == 3) m_killed[5] = 1;
      if (i >= 3 && i < 11) o = smp(5, int'($urandom_range(1, 1000)));
      if (i == 11) shutdown_in[5] = 1'b0;
      if (i >= 11 && i - 11 < DEB) o = smp(5, int'($urandom_range(1, 1000)));
      if (i - 11 == DEB + 3) m_killed[5] = 0;
      if (i - 11 >= DEB + 3 && i - 11 < DEB + 6) o = smp(5, int'($urandom_range(1, 1000)));
      issue(o);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL kill i=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_zero_fault();
    op_t q[$];
    repeat (4) q.push_back(smp(1, 0));
    q.push_back(smp(1, 7));
    q.push_back(idl());
    q.push_back(wr(CLR, 16'h0002));
    q.push_back(smp(1, 7));
    repeat (4) q.push_back(smp(4, 0));
    q.push_back(wr(CLR, 16'h0010));
    repeat (3) q.push_back(smp(4, 0));
    q.push_back(idl());
    q.push_back(idl());
    q.push_back(smp(4, 0));
    q.push_back(smp(4, 9));
    q.push_back(idl());
    q.push_back(idl());
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL zero_fault step=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_step();
    op_t q[$];
    q.push_back(wr(THR, 16'd10));
    q.push_back(smp(0, 1000));
    q.push_back(smp(0, 1010));
    q.push_back(smp(0, 1011));
    q.push_back(smp(0, 1021));
    q.push_back(smp(0, 1500));
    q.push_back(smp(0, 1030));
    q.push_back(idl());
    q.push_back(idl());
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL step step=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_back_to_back();
    op_t q[$];
    q.push_back(wr(THR, 16'd1));
    q.push_back(wr(CLR, 16'h0008));
    q.push_back(smp(3, -131072));
    q.push_back(smp(3, 131071));
    q.push_back(wr(CLR, 16'h0008));
    q.push_back(smp(3, 20));
    q.push_back(smp(3, 21));
    q.push_back(smp(3, 22));
    q.push_back(smp(3, 24));
    q.push_back(smp(3, 23));
    q.push_back(smp(3, 22));
    q.push_back(idl());
    q.push_back(idl());
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL back_to_back step=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_random();
    op_t o;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      o = idl();
      if ($urandom_range(0, 3) != 0) begin
        o.dv = 1;
        o.ch = int'($urandom_range(0, 7));
        o.d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 60)) - 30;
      end
      if (r < 8) begin
        o.we = 1;
        o.a = THR;
        o.w = 16'($urandom_range(0, 25));
      end else if (r < 13) begin
        o.we = 1;
        o.a = CLR;
        o.w = 16'($urandom_range(0, 255));
      end else if (r < 16) begin
        o.we = 1;
        o.a = 16'h42;
        o.w = 16'($urandom);
      end
      issue(o);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL random i=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  task automatic test_async_reset();
    op_t q[$];
    q.push_back(wr(THR, 16'd10));
    q.push_back(wr(CLR, 16'h00ff));
    q.push_back(smp(0, 100));
    q.push_back(smp(6, 0));
    q.push_back(smp(0, 105));
    q.push_back(smp(0, 110));
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL async_reset pre step=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
    #2;
    rst_in = 1'b1;
    dv_in = 1'b0;
    wr_en = 1'b0;
    #1;
    n_tests++;
    if ({dv_out, chan_out, data_out, fault_out} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_assert: got dv=%b ch=%0d data=%h fault=%h, want all 0", dv_out, chan_out, data_out, fault_out);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    m_reset();
    q.delete();
    repeat (DEB + 3) q.push_back(idl());
    foreach (q[i]) begin
      if (i == DEB + 2) m_release();
      issue(i == DEB + 2 ? smp(0, 100) : idl());
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL async_reset post i=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
    q.delete();
    q.push_back(smp(0, 5000));
    q.push_back(smp(0, -5000));
    q.push_back(idl());
    q.push_back(idl());
    foreach (q[i]) begin
      issue(q[i]);
      n_tests++;
      if (dv_out !== e_dv || (e_dv && (chan_out !== e_ch || data_out !== e_data)) || fault_out !== e_fault) begin
        n_fail++;
        $display("FAIL async_reset thr_zero step=%0d: got dv=%b ch=%0d data=%0d fault=%h, want dv=%b ch=%0d data=%0d fault=%h", i, dv_out, chan_out, $signed(data_out), fault_out, e_dv, e_ch, $signed(e_data), e_fault);
      end
    end
  endtask
  initial begin
    rst_in = 1'b1;
    shutdown_in = '0;
    dv_in = 1'b0;
    chan_in = '0;
    data_in = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    m_reset();
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    test_release();
    test_kill();
    test_zero_fault();
    test_step();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
